rram_access_sequencer: RTL and testbench

RRAM_ACCESS_SEQUENCER -- requirements
Module: rram_access_sequencer

---
 rtl/rram_access_sequencer_pkg.sv | 21 ++
 rtl/rram_access_sequencer.sv | 133 +++++++++++++
 tb/tb_rram_access_sequencer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rram_access_sequencer_pkg.sv
// Shared types and default geometry for the RRAM access sequencer.
package rram_access_sequencer_pkg;

    localparam int unsigned B_SIZE_DEF = 4;
    localparam int unsigned X_SIZE_DEF = 3;
    localparam int unsigned Y_SIZE_DEF = 5;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Counter preload: the last EN cycle is the one where the counter reads 0.
    function automatic logic [CNT_W-1:0] cycles_to_count(input int unsigned cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/rram_access_sequencer.sv
// Single-request RRAM sequencer: 1 setup cycle, RD/WR_CYCLES of EN, response 2+N cycles after accept.
// One op in flight; req_ready only in IDLE; response held in DONE until rsp_ready.
module rram_access_sequencer
    import rram_access_sequencer_pkg::*;
#(
    parameter int unsigned B_SIZE    = B_SIZE_DEF,
    parameter int unsigned X_SIZE    = X_SIZE_DEF,
    parameter int unsigned Y_SIZE    = Y_SIZE_DEF,
    parameter int unsigned RD_CYCLES = 4,
    parameter int unsigned WR_CYCLES = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_rw,
    input  logic [X_SIZE+Y_SIZE-1:0] req_addr,
    input  logic [B_SIZE-1:0]        req_wdata,
    output logic                     EN,
    output logic                     RW,
    output logic [X_SIZE-1:0]        X_ADDRESS_IN,
    output logic [Y_SIZE-1:0]        Y_ADDRESS_IN,
    output logic [B_SIZE-1:0]        WDATA,
    input  logic [B_SIZE-1:0]        SA_DATA,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [B_SIZE-1:0]        rsp_rdata,
    output logic                     rsp_rw
);

    localparam logic [CNT_W-1:0] RD_CNT = cycles_to_count(RD_CYCLES);
    localparam logic [CNT_W-1:0] WR_CNT = cycles_to_count(WR_CYCLES);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                en_q, en_d;
    logic                rw_q, rw_d;
    logic [X_SIZE-1:0]   x_q, x_d;
    logic [Y_SIZE-1:0]   y_q, y_d;
    logic [B_SIZE-1:0]   wdata_q, wdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [B_SIZE-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_rw_q, rsp_rw_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            en_q        <= 1'b0;
            rw_q        <= 1'b1;
            x_q         <= '0;
            y_q         <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_rw_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            en_q        <= en_d;
            rw_q        <= rw_d;
            x_q         <= x_d;
            y_q         <= y_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_rw_q    <= rsp_rw_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        en_d        = en_q;
        rw_d        = rw_q;
        x_d         = x_q;
        y_d         = y_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_rw_d    = rsp_rw_q;

        case (state_q)
            IDLE: begin
                // Array-side address/data registers load on accept so they are valid throughout SETUP.
                if (req_valid) begin
                    state_d = SETUP;
                    rw_d    = req_rw;
                    x_d     = req_addr[X_SIZE-1:0];
                    y_d     = req_addr[X_SIZE +: Y_SIZE];
                    wdata_d = req_wdata;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = rw_q ? RD_CNT : WR_CNT;
                en_d    = 1'b1;
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d     = DONE;
                    en_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rw_d    = rw_q;
                    rsp_rdata_d = rw_q ? SA_DATA : '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                en_d    = 1'b0;
            end
        endcase
    end

    assign req_ready    = (state_q == IDLE);
    assign EN           = en_q;
    assign RW           = rw_q;
    assign X_ADDRESS_IN = x_q;
    assign Y_ADDRESS_IN = y_q;
    assign WDATA        = wdata_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_rw       = rsp_rw_q;

endmodule

// File: tb/tb_rram_access_sequencer.sv
// Directed bench for rram_access_sequencer: vector table plus hand-written corner sequences.
module tb_rram_access_sequencer;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic       req_rw;
    logic [7:0] req_addr;
    logic [3:0] req_wdata;
    logic       EN;
    logic       RW;
    logic [2:0] X_ADDRESS_IN;
    logic [4:0] Y_ADDRESS_IN;
    logic [3:0] WDATA;
    logic [3:0] SA_DATA;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_rdata;
    logic       rsp_rw;

    int total = 0;
    int bad   = 0;

    rram_access_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_rw       (req_rw),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .EN           (EN),
        .RW           (RW),
        .X_ADDRESS_IN (X_ADDRESS_IN),
        .Y_ADDRESS_IN (Y_ADDRESS_IN),
        .WDATA        (WDATA),
        .SA_DATA      (SA_DATA),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_rw       (rsp_rw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rw;
        logic [7:0] addr;
        logic [3:0] wdata;
        logic [3:0] sa;
        logic [2:0] x;
        logic [4:0] y;
        int         en_cyc;
        int         lat;
        logic [3:0] rdata;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called just after a negedge with rsp_ready=1; ends one negedge after the response handshake.
    task automatic run_op(input vec_t v);
        int  en_cnt = 0;
        int  lat    = 0;
        bit  got    = 0;
        bit  stable = 1;
        chk("op_ready", req_ready, 1);
        req_valid = 1'b1;
        req_rw    = v.rw;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        SA_DATA   = v.sa;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (k == 1) begin
                chk("setup_en", EN, 0);
                chk("setup_x", X_ADDRESS_IN, v.x);
                chk("setup_y", Y_ADDRESS_IN, v.y);
                chk("setup_rw", RW, v.rw);
                chk("setup_wdata", WDATA, v.wdata);
            end
            if (EN) begin
                en_cnt++;
                if (X_ADDRESS_IN !== v.x || Y_ADDRESS_IN !== v.y || RW !== v.rw || WDATA !== v.wdata)
                    stable = 0;
            end
            if (rsp_valid) begin
                got = 1;
                lat = k;
                break;
            end
        end
        chk("rsp_seen", got, 1);
        chk("latency", lat, v.lat);
        chk("en_cycles", en_cnt, v.en_cyc);
        chk("addr_stable", stable, 1);
        chk("rsp_rdata", rsp_rdata, v.rdata);
        chk("rsp_rw", rsp_rw, v.rw);
        chk("done_en", EN, 0);
        @(negedge clk);
        chk("rsp_drop", rsp_valid, 0);
        chk("idle_ready", req_ready, 1);
    endtask

    initial begin
        vecs[0] = '{rw:1'b1, addr:8'h2A, wdata:4'h0, sa:4'hB, x:3'd2, y:5'd5,  en_cyc:4, lat:6,  rdata:4'hB};
        vecs[1] = '{rw:1'b0, addr:8'hFF, wdata:4'h5, sa:4'hA, x:3'd7, y:5'd31, en_cyc:8, lat:10, rdata:4'h0};
        vecs[2] = '{rw:1'b1, addr:8'h00, wdata:4'h3, sa:4'hF, x:3'd0, y:5'd0,  en_cyc:4, lat:6,  rdata:4'hF};
        vecs[3] = '{rw:1'b0, addr:8'h81, wdata:4'hA, sa:4'h7, x:3'd1, y:5'd16, en_cyc:8, lat:10, rdata:4'h0};
        vecs[4] = '{rw:1'b1, addr:8'hC7, wdata:4'h9, sa:4'h6, x:3'd7, y:5'd24, en_cyc:4, lat:6,  rdata:4'h6};

        reset     = 1'b1;
        req_valid = 1'b0;
        req_rw    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        SA_DATA   = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_en", EN, 0);
        chk("rst_rw", RW, 1);
        chk("rst_x", X_ADDRESS_IN, 0);
        chk("rst_y", Y_ADDRESS_IN, 0);
        chk("rst_wdata", WDATA, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_rw", rsp_rw, 0);
        chk("rst_req_ready", req_ready, 1);

        // Consecutive vectors run back-to-back: each accept lands one cycle after the prior handshake.
        for (int i = 0; i < 5; i++) run_op(vecs[i]);

        // Backpressure: hold the response for 10 cycles while SA_DATA moves underneath.
        begin
            bit got  = 0;
            bit hold = 1;
            rsp_ready = 1'b0;
            req_valid = 1'b1;
            req_rw    = 1'b1;
            req_addr  = 8'h2A;
            SA_DATA   = 4'h9;
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk);
                req_valid = 1'b0;
                if (rsp_valid) begin
                    got = 1;
                    break;
                end
            end
            chk("bp_rsp_seen", got, 1);
            SA_DATA = 4'h3;
            for (int k = 0; k < 10; k++) begin
                if (rsp_valid !== 1'b1 || rsp_rdata !== 4'h9 || req_ready !== 1'b0 || EN !== 1'b0)
                    hold = 0;
                @(negedge clk);
            end
            chk("bp_hold", hold, 1);
            chk("bp_still_valid", rsp_valid, 1);
            rsp_ready = 1'b1;
            @(negedge clk);
            chk("bp_release", rsp_valid, 0);
            chk("bp_ready", req_ready, 1);
        end

        // Busy request during ACCESS must be dropped, not queued.
        begin
            int rsp_cnt = 0;
            int en_cnt  = 0;
            logic [3:0] rd = '0;
            req_valid = 1'b1;
            req_rw    = 1'b1;
            req_addr  = 8'h2A;
            SA_DATA   = 4'hC;
            for (int k = 1; k <= 30; k++) begin
                @(negedge clk);
                req_valid = 1'b0;
                if (k >= 3 && k <= 5) begin
                    req_valid = 1'b1;
                    req_rw    = 1'b0;
                    req_addr  = 8'h11;
                end
                if (EN) en_cnt++;
                if (rsp_valid) begin
                    rsp_cnt++;
                    rd = rsp_rdata;
                end
            end
            req_valid = 1'b0;
            chk("busy_rsp_count", rsp_cnt, 1);
            chk("busy_en_cycles", en_cnt, 4);
            chk("busy_rdata", rd, 4'hC);
            chk("busy_x_kept", X_ADDRESS_IN, 3'd2);
        end

        // Reset on the second EN cycle of a write.
        begin
            bit quiet = 1;
            req_valid = 1'b1;
            req_rw    = 1'b0;
            req_addr  = 8'hFF;
            req_wdata = 4'h5;
            @(negedge clk);
            req_valid = 1'b0;
            @(negedge clk);
            @(negedge clk);
            chk("mid_en_before", EN, 1);
            #2 reset = 1'b1;
            #1;
            chk("mid_en", EN, 0);
            chk("mid_rw", RW, 1);
            chk("mid_x", X_ADDRESS_IN, 0);
            chk("mid_y", Y_ADDRESS_IN, 0);
            chk("mid_wdata", WDATA, 0);
            chk("mid_rsp_valid", rsp_valid, 0);
            chk("mid_rsp_rdata", rsp_rdata, 0);
            chk("mid_rsp_rw", rsp_rw, 0);
            chk("mid_req_ready", req_ready, 1);
            @(negedge clk);
            reset = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (rsp_valid !== 1'b0 || EN !== 1'b0) quiet = 0;
            end
            chk("mid_no_rsp", quiet, 1);
        end

        // Sequencer still usable after the abandoned write.
        run_op(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
